video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Downstream consumer of the video mode selector.
- Parent unpacks the selected VideoMode into raw timing fields.
- This block generates the raster: h/v counters, hsync, vsync, data-enable and frame markers for the HDMI pixel pipeline.
- Mode changes are detected internally and applied only on a frame boundary, so the sink never sees a torn frame.

Parameters:
H_WIDTH, 12, width of all horizontal timing fields and h_count
V_WIDTH, 11, width of all vertical timing fields and v_count

Ports:
clock  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
h_active/h_front/h_sync/h_back  in  H_WIDTH each  horizontal region lengths, pixels
v_active/v_front/v_sync/v_back  in  V_WIDTH each  vertical region lengths, lines
hsync_pol, vsync_pol  in  1 each  active level of the sync pulse
interlaced  in  1  mode is interlaced (used only with optional feature)
hsync, vsync  out  1 each  sync outputs, registered
de  out  1  data enable, high in the active area
h_count  out  H_WIDTH  pixel position, registered
v_count  out  V_WIDTH  line position, registered
frame_start  out  1  one-cycle pulse at h=0, v=0
mode_applied  out  1  one-cycle pulse when new timing is loaded
field  out  1  current field (0 for progressive)

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, shadow timing registers 0, state IDLE.
- Sums: h_total = sum of the four h fields; v_total = sum of the four v fields. Sums are computed in H_WIDTH/V_WIDTH; overflow is the parent's responsibility.
- States:
  - IDLE:
    - Each cycle, latch all inputs into the shadows.
    - If every h_* and v_* field is nonzero, go to RUN with counters at 0.
    - Otherwise stay in IDLE with outputs at 0.
  - RUN:
    - h_count increments each clock, wrapping at h_total-1 to 0.
    - On the wrap, v_count increments, wrapping at v_total-1 to 0.
- Region order per line: active [0, h_active), front porch, sync [h_active+h_front, h_active+h_front+h_sync), back porch. Vertical uses the same ordering in lines.
- Outputs are registered, one cycle of latency: outputs in cycle n describe the counter position of cycle n-1.
  - de = horizontal active AND vertical active.
  - hsync = hsync_pol inside the h sync region, else ~hsync_pol.
  - vsync = vsync_pol on lines inside the v sync region, else ~vsync_pol. It changes at h=0 of the line.
  - frame_start asserts for position (0,0).
- Mode change detection:
  - In RUN, any input field that differs from its shadow sets pending.
  - At the last pixel of the frame (h=h_total-1, v=v_total-1, and field=1 when interlace is active), if pending:
    - reload the shadows from the current inputs;
    - clear pending;
    - pulse mode_applied with the first cycle of the new frame.
  - If the new inputs contain a zero field, go to IDLE instead (no pulse).
- Inputs changing again while pending is set: the latest values at the frame boundary win.
- Inputs changing on the boundary cycle itself: the new values load on that boundary.
- Inputs are assumed to be stable in the clock domain; no synchronisers are included.

Optional Feature:
- Macro VIDEO_INTERLACE_EN, with shadow interlaced=1:
  - field toggles at each field end.
  - Field 0 uses v_total lines; field 1 uses v_total+1 lines (extra line in the back porch).
  - In field 1, vsync asserts and deasserts at h = h_total>>1 of the respective lines instead of h=0.
  - frame_start pulses only at the start of field 0.
- Without the macro: the interlaced port is ignored, field is tied to 0, and all frames are progressive.

Test Plan:
- 640x480 (h 640/16/96/48, v 480/10/2/33, pols 0) -> h_total 800, v_total 525; 640 de cycles per active line; hsync low for h 656..751; frame_start period 420000 cycles.
- Run 640x480, switch inputs to 720p (1280/110/40/220, 750 lines, pols 1) mid-frame at v=100 -> old timing continues to v=524; mode_applied and frame_start coincide; next line period 1650; hsync high for h 1390..1429.
- Set h_sync=0 with other fields valid -> block stays in IDLE; hsync/vsync/de remain 0. Set h_sync=96 -> RUN, frame_start on the following output cycle.
- Assert reset_n low at h=300, v=200 -> all outputs 0 immediately (async). Release -> counting restarts at (0,0); frame_start one cycle after the first RUN cycle.
- VIDEO_INTERLACE_EN, 1080i (h 1920/88/44/148, v 540/2/5/15, interlaced=1) -> field 0 has 562 lines, field 1 has 563; field-1 vsync edges at h=1100; frame_start every 2,475,000 cycles.
- Toggle interlaced only (without the macro) -> no pending or mode_applied is required beyond one reload; field stays 0; timing is unchanged.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster generator: h/v counters, syncs, data enable and frame markers, with mode changes
// deferred to a frame boundary. Define VIDEO_INTERLACE_EN to enable interlaced field timing.
module video_timing_gen #(
    parameter int H_WIDTH = 12,
    parameter int V_WIDTH = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [H_WIDTH-1:0] h_active,
    input  logic [H_WIDTH-1:0] h_front,
    input  logic [H_WIDTH-1:0] h_sync,
    input  logic [H_WIDTH-1:0] h_back,
    input  logic [V_WIDTH-1:0] v_active,
    input  logic [V_WIDTH-1:0] v_front,
    input  logic [V_WIDTH-1:0] v_sync,
    input  logic [V_WIDTH-1:0] v_back,
    input  logic               hsync_pol,
    input  logic               vsync_pol,
    input  logic               interlaced,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [H_WIDTH-1:0] h_count,
    output logic [V_WIDTH-1:0] v_count,
    output logic               frame_start,
    output logic               mode_applied,
    output logic               field
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [H_WIDTH-1:0] hc_q, hc_d;
    logic [V_WIDTH-1:0] vc_q, vc_d;
    logic               fld_q, fld_d;
    logic               pending_q, pending_d;
    logic               loaded_q, loaded_d;
    logic               load_shadow;

    logic [H_WIDTH-1:0] sh_h_active, sh_h_front, sh_h_sync, sh_h_back;
    logic [V_WIDTH-1:0] sh_v_active, sh_v_front, sh_v_sync, sh_v_back;
    logic               sh_hsync_pol, sh_vsync_pol;
    logic               ilace, ilace_differ;

`ifdef VIDEO_INTERLACE_EN
    logic sh_interlaced;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_interlaced <= 1'b0;
        end else if (load_shadow) begin
            sh_interlaced <= interlaced;
        end
    end
    assign ilace        = sh_interlaced;
    assign ilace_differ = interlaced != sh_interlaced;
`else
    logic unused_interlaced;
    assign unused_interlaced = interlaced;
    assign ilace             = 1'b0;
    assign ilace_differ      = 1'b0;
`endif

    logic [H_WIDTH-1:0] h_total, h_last, h_half, hs_start, hs_end;
    logic [V_WIDTH-1:0] v_total, v_last, vs_start, vs_end;
    logic inputs_valid, differ, line_end, frame_end, boundary;
    logic h_act, v_act, h_in_sync, v_in_sync, v_after_start, v_before_end;

    assign h_total  = sh_h_active + sh_h_front + sh_h_sync + sh_h_back;
    assign h_last   = h_total - H_WIDTH'(1);
    assign h_half   = h_total >> 1;
    assign hs_start = sh_h_active + sh_h_front;
    assign hs_end   = hs_start + sh_h_sync;
    assign v_total  = sh_v_active + sh_v_front + sh_v_sync + sh_v_back;
    // Field 1 of an interlaced frame carries one extra back-porch line.
    assign v_last   = v_total - V_WIDTH'(1) + {{(V_WIDTH-1){1'b0}}, ilace & fld_q};
    assign vs_start = sh_v_active + sh_v_front;
    assign vs_end   = vs_start + sh_v_sync;

    assign inputs_valid = (|h_active) && (|h_front) && (|h_sync) && (|h_back) &&
                          (|v_active) && (|v_front) && (|v_sync) && (|v_back);
    assign differ = (h_active != sh_h_active) || (h_front != sh_h_front) ||
                    (h_sync != sh_h_sync) || (h_back != sh_h_back) ||
                    (v_active != sh_v_active) || (v_front != sh_v_front) ||
                    (v_sync != sh_v_sync) || (v_back != sh_v_back) ||
                    (hsync_pol != sh_hsync_pol) || (vsync_pol != sh_vsync_pol) || ilace_differ;

    assign line_end  = hc_q == h_last;
    assign frame_end = line_end && (vc_q == v_last);
    assign boundary  = frame_end && (!ilace || fld_q);

    assign h_act         = hc_q < sh_h_active;
    assign v_act         = vc_q < sh_v_active;
    assign h_in_sync     = (hc_q >= hs_start) && (hc_q < hs_end);
    // In field 1 the vertical sync edges sit at mid-line.
    assign v_after_start = (vc_q > vs_start) || ((vc_q == vs_start) && (hc_q >= h_half));
    assign v_before_end  = (vc_q < vs_end) || ((vc_q == vs_end) && (hc_q < h_half));
    assign v_in_sync     = (ilace && fld_q) ? (v_after_start && v_before_end)
                                            : ((vc_q >= vs_start) && (vc_q < vs_end));

    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        vc_d        = vc_q;
        fld_d       = fld_q;
        pending_d   = pending_q;
        loaded_d    = 1'b0;
        load_shadow = 1'b0;
        case (state_q)
            IDLE: begin
                load_shadow = 1'b1;
                hc_d        = '0;
                vc_d        = '0;
                fld_d       = 1'b0;
                pending_d   = 1'b0;
                if (inputs_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                pending_d = pending_q | differ;
                if (line_end) begin
                    hc_d = '0;
                    if (vc_q == v_last) begin
                        vc_d  = '0;
                        fld_d = ilace ? ~fld_q : 1'b0;
                    end else begin
                        vc_d = vc_q + V_WIDTH'(1);
                    end
                end else begin
                    hc_d = hc_q + H_WIDTH'(1);
                end
                if (boundary && (pending_q || differ)) begin
                    load_shadow = 1'b1;
                    pending_d   = 1'b0;
                    fld_d       = 1'b0;
                    if (inputs_valid) begin
                        loaded_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            hc_q      <= '0;
            vc_q      <= '0;
            fld_q     <= 1'b0;
            pending_q <= 1'b0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            fld_q     <= fld_d;
            pending_q <= pending_d;
            loaded_q  <= loaded_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_h_active  <= '0;
            sh_h_front   <= '0;
            sh_h_sync    <= '0;
            sh_h_back    <= '0;
            sh_v_active  <= '0;
            sh_v_front   <= '0;
            sh_v_sync    <= '0;
            sh_v_back    <= '0;
            sh_hsync_pol <= 1'b0;
            sh_vsync_pol <= 1'b0;
        end else if (load_shadow) begin
            sh_h_active  <= h_active;
            sh_h_front   <= h_front;
            sh_h_sync    <= h_sync;
            sh_h_back    <= h_back;
            sh_v_active  <= v_active;
            sh_v_front   <= v_front;
            sh_v_sync    <= v_sync;
            sh_v_back    <= v_back;
            sh_hsync_pol <= hsync_pol;
            sh_vsync_pol <= vsync_pol;
        end
    end

    // Output stage: one cycle behind the counters; held at zero outside RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            de           <= 1'b0;
            h_count      <= '0;
            v_count      <= '0;
            frame_start  <= 1'b0;
            mode_applied <= 1'b0;
            field        <= 1'b0;
        end else if (state_q == RUN) begin
            hsync        <= h_in_sync ? sh_hsync_pol : ~sh_hsync_pol;
            vsync        <= v_in_sync ? sh_vsync_pol : ~sh_vsync_pol;
            de           <= h_act && v_act;
            h_count      <= hc_q;
            v_count      <= vc_q;
            frame_start  <= (hc_q == '0) && (vc_q == '0) && !(ilace && fld_q);
            mode_applied <= loaded_q;
            field        <= ilace & fld_q;
        end else begin
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            de           <= 1'b0;
            h_count      <= '0;
            v_count      <= '0;
            frame_start  <= 1'b0;
            mode_applied <= 1'b0;
            field        <= 1'b0;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: expected raster samples are generated per mode and
// compared cycle by cycle against the registered outputs.
module tb_video_timing_gen;
    logic        clock;
    logic        reset_n;
    logic [11:0] h_active, h_front, h_sync, h_back;
    logic [10:0] v_active, v_front, v_sync, v_back;
    logic        hsync_pol, vsync_pol, interlaced;
    logic        hsync, vsync, de, frame_start, mode_applied, field;
    logic [11:0] h_count;
    logic [10:0] v_count;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp, il;
    } mode_t;

    logic [28:0] sb_q[$];
    logic [28:0] sb_exp;
    logic [28:0] outs;
    int          total = 0;
    int          bad = 0;
    int          sb_idx = 0;
    mode_t       ma, mb, mc, mz, m640;

    video_timing_gen #(.H_WIDTH(12), .V_WIDTH(11)) dut (
        .clock(clock), .reset_n(reset_n),
        .h_active(h_active), .h_front(h_front), .h_sync(h_sync), .h_back(h_back),
        .v_active(v_active), .v_front(v_front), .v_sync(v_sync), .v_back(v_back),
        .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .interlaced(interlaced),
        .hsync(hsync), .vsync(vsync), .de(de), .h_count(h_count), .v_count(v_count),
        .frame_start(frame_start), .mode_applied(mode_applied), .field(field)
    );

    assign outs = {hsync, vsync, de, frame_start, mode_applied, field, h_count, v_count};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] pack(input bit hs, input bit vs, input bit d, input bit fs,
                                         input bit ap, input bit fd, input int h, input int v);
        return {hs, vs, d, fs, ap, fd, 12'(h), 11'(v)};
    endfunction

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            sb_exp = sb_q.pop_front();
            check($sformatf("sb%0d", sb_idx), {3'b0, outs}, {3'b0, sb_exp});
            sb_idx++;
        end
    end

    task automatic push_zero(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back('0);
    endtask

    // One field of expected samples in raster order; max_lines > 0 truncates the field.
    task automatic push_field(input mode_t m, input bit fld, input bit applied, input int max_lines);
        int ht, vt, hs0, hs1, vs0, vs1, half, nl, p;
        bit hsa, vsa;
        ht   = m.ha + m.hf + m.hs + m.hb;
        vt   = m.va + m.vf + m.vs + m.vb + (fld ? 1 : 0);
        hs0  = m.ha + m.hf;
        hs1  = hs0 + m.hs;
        vs0  = m.va + m.vf;
        vs1  = vs0 + m.vs;
        half = ht / 2;
        nl   = (max_lines > 0 && max_lines < vt) ? max_lines : vt;
        for (int v = 0; v < nl; v++) begin
            for (int h = 0; h < ht; h++) begin
                p   = v * ht + h;
                hsa = (h >= hs0) && (h < hs1);
                if (fld) vsa = (p >= vs0 * ht + half) && (p < vs1 * ht + half);
                else     vsa = (v >= vs0) && (v < vs1);
                sb_q.push_back(pack(hsa ? m.hp : !m.hp, vsa ? m.vp : !m.vp,
                                    (h < m.ha) && (v < m.va), (h == 0) && (v == 0) && !fld,
                                    applied && (h == 0) && (v == 0), fld, h, v));
            end
        end
    endtask

    task automatic apply_mode(input mode_t m);
        h_active = 12'(m.ha); h_front = 12'(m.hf); h_sync = 12'(m.hs); h_back = 12'(m.hb);
        v_active = 11'(m.va); v_front = 11'(m.vf); v_sync = 11'(m.vs); v_back = 11'(m.vb);
        hsync_pol = m.hp; vsync_pol = m.vp; interlaced = m.il;
    endtask

    // Reset, release just after an edge, and expect two idle samples before position (0,0).
    task automatic start_mode(input mode_t m);
        reset_n = 1'b0;
        apply_mode(m);
        repeat (2) @(posedge clock);
        #1 check("reset_out", {3'b0, outs}, 32'h0);
        reset_n = 1'b1;
        push_zero(2);
    endtask

    task automatic wait_q(input int level);
        for (int i = 0; i < 20000 && sb_q.size() > level; i++) @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20000 && sb_q.size() > 0; i++) @(posedge clock);
        check(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        ma   = '{8, 2, 3, 3, 5, 1, 2, 2, 1'b0, 1'b0, 1'b0};
        mb   = '{10, 3, 2, 4, 6, 2, 1, 3, 1'b1, 1'b1, 1'b0};
        mc   = '{12, 1, 1, 2, 4, 1, 1, 1, 1'b0, 1'b1, 1'b0};
        mz   = mb;
        mz.hs = 0;
        m640 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        apply_mode(ma);
        #3 check("reset_init", {3'b0, outs}, 32'h0);

        // Mid-frame change (C then B): old timing finishes, B applies on the boundary.
        start_mode(ma);
        for (int f = 0; f < 3; f++) push_field(ma, 1'b0, 1'b0, 0);
        push_field(mb, 1'b0, 1'b1, 0);
        push_field(mb, 1'b0, 1'b0, 0);
        push_zero(20);
        wait_q(456 + 20 + 160 - 3 * 16);
        apply_mode(mc);
        repeat (5) @(posedge clock);
        #1 apply_mode(mb);
        // A zero field takes effect at the frame end and parks the block in IDLE.
        wait_q(20 + 114);
        apply_mode(mz);
        drain("drain_switch");

        @(posedge clock);
        #1 apply_mode(mb);
        push_zero(2);
        push_field(mb, 1'b0, 1'b0, 0);
        drain("drain_restart");

        // 640x480 lines, then an asynchronous reset mid-line and a clean restart.
        start_mode(m640);
        push_field(m640, 1'b0, 1'b0, 2);
        drain("drain_640");
        repeat (300) @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {3'b0, outs}, 32'h0);
        start_mode(m640);
        push_field(m640, 1'b0, 1'b0, 1);
        drain("drain_640_rst");

`ifdef VIDEO_INTERLACE_EN
        ma.il = 1'b1;
        start_mode(ma);
        push_field(ma, 1'b0, 1'b0, 0);
        push_field(ma, 1'b1, 1'b0, 0);
        push_field(ma, 1'b0, 1'b0, 0);
        drain("drain_ilace");
`else
        // The interlaced input has no effect on timing or field in a progressive build.
        start_mode(ma);
        push_field(ma, 1'b0, 1'b0, 0);
        push_field(ma, 1'b0, 1'b0, 0);
        push_field(ma, 1'b0, 1'b0, 0);
        wait_q(160 + 80);
        interlaced = 1'b1;
        drain("drain_ilace_off");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
